// File: rtl/aurora_lock_supervisor.sv
// Per-channel GT lock supervisor: synchronises raw PLL lock, qualifies it over a
// programmable stable interval, aggregates enabled channels and counts lock losses.
module aurora_lock_supervisor #(
  parameter int unsigned NUM_CHANNELS       = 1,
  parameter int unsigned LOCK_STABLE_CYCLES = 1024,
  parameter int unsigned CNT_WIDTH          = 16,
  parameter int unsigned LOSS_CNT_WIDTH     = 8
) (
  input  logic                                     USER_CLK,
  input  logic                                     RESET_N,
  input  logic [NUM_CHANNELS-1:0]                  GT_CLK_LOCKED,
  input  logic [NUM_CHANNELS-1:0]                  CHANNEL_ENABLE,
  input  logic                                     CLEAR_COUNTS,
  output logic [NUM_CHANNELS-1:0]                  LOCKED_STABLE,
  output logic                                     PLL_NOT_LOCKED,
  output logic [NUM_CHANNELS*LOSS_CNT_WIDTH-1:0]   LOSS_COUNT
);

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_QUALIFY  = 2'd1,
    ST_LOCKED   = 2'd2
  } state_e;

  localparam logic [CNT_WIDTH-1:0]      QUAL_LAST = CNT_WIDTH'(LOCK_STABLE_CYCLES - 1);
  localparam logic [LOSS_CNT_WIDTH-1:0] LOSS_MAX  = '1;

  logic [NUM_CHANNELS-1:0]   sync1_q;
  logic [NUM_CHANNELS-1:0]   s2;
  state_e                    state_q [NUM_CHANNELS];
  state_e                    state_d [NUM_CHANNELS];
  logic [CNT_WIDTH-1:0]      cnt_q   [NUM_CHANNELS];
  logic [CNT_WIDTH-1:0]      cnt_d   [NUM_CHANNELS];
  logic [LOSS_CNT_WIDTH-1:0] loss_q  [NUM_CHANNELS];
  logic [LOSS_CNT_WIDTH-1:0] loss_d  [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0]   loss_ev;
  logic [NUM_CHANNELS-1:0]   locked_q;
  logic [NUM_CHANNELS-1:0]   locked_d;
  logic                      all_ok;
  logic                      pnl_q;
  logic                      pnl_d;

  // Two-flop synchroniser; s2 is the only consumer-visible view of the raw lock.
  always_ff @(posedge USER_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1_q <= '0;
      s2      <= '0;
    end else begin
      sync1_q <= GT_CLK_LOCKED;
      s2      <= sync1_q;
    end
  end

  // State, qualification counter, loss counter and output registers.
  always_ff @(posedge USER_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
        state_q[i] <= ST_UNLOCKED;
        cnt_q[i]   <= '0;
        loss_q[i]  <= '0;
      end
      locked_q <= '0;
      pnl_q    <= 1'b1;
    end else begin
      for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        loss_q[i]  <= loss_d[i];
      end
      locked_q <= locked_d;
      pnl_q    <= pnl_d;
    end
  end

  // Per-channel next state; disable overrides everything and never counts a loss.
  always_comb begin
    loss_ev  = '0;
    locked_d = '0;
    for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      loss_d[i]  = loss_q[i];
      if (!CHANNEL_ENABLE[i]) begin
        state_d[i] = ST_UNLOCKED;
        cnt_d[i]   = '0;
      end else begin
        case (state_q[i])
          ST_UNLOCKED: begin
            cnt_d[i] = '0;
            if (s2[i]) state_d[i] = ST_QUALIFY;
          end
          ST_QUALIFY: begin
            if (!s2[i]) begin
              state_d[i] = ST_UNLOCKED;
              cnt_d[i]   = '0;
            end else if (cnt_q[i] == QUAL_LAST) begin
              state_d[i] = ST_LOCKED;
              cnt_d[i]   = '0;
            end else begin
              cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
            end
          end
          ST_LOCKED: begin
            if (!s2[i]) begin
              state_d[i] = ST_UNLOCKED;
              loss_ev[i] = 1'b1;
            end
          end
          default: begin
            state_d[i] = ST_UNLOCKED;
            cnt_d[i]   = '0;
          end
        endcase
      end
      if (CLEAR_COUNTS) begin
        loss_d[i] = '0;
      end else if (loss_ev[i] && (loss_q[i] != LOSS_MAX)) begin
        loss_d[i] = loss_q[i] + LOSS_CNT_WIDTH'(1);
      end
      locked_d[i] = (state_d[i] == ST_LOCKED);
    end
  end

  // Aggregate: low only when some channel is enabled and every enabled one is locked.
  always_comb begin
    all_ok = 1'b1;
    for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
      if (CHANNEL_ENABLE[i] && !locked_q[i]) all_ok = 1'b0;
    end
    pnl_d = !((|CHANNEL_ENABLE) && all_ok);
  end

  assign LOCKED_STABLE  = locked_q;
  assign PLL_NOT_LOCKED = pnl_q;

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_loss_out
    assign LOSS_COUNT[g*LOSS_CNT_WIDTH +: LOSS_CNT_WIDTH] = loss_q[g];
  end

endmodule

// File: tb/tb_aurora_lock_supervisor.sv
// Table-driven bench for aurora_lock_supervisor (2 channels, L=16, 4-bit loss counters)
// with expected values queued at drive time and compared after the edges elapse.
module tb_aurora_lock_supervisor;

  localparam int unsigned NCH = 2;
  localparam int unsigned LSC = 16;
  localparam int unsigned LCW = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NCH-1:0]   gt_lock;
  logic [NCH-1:0]   ch_en;
  logic             clr;
  logic [NCH-1:0]   locked_stable;
  logic             pll_not_locked;
  logic [NCH*LCW-1:0] loss_count;

  aurora_lock_supervisor #(
    .NUM_CHANNELS      (NCH),
    .LOCK_STABLE_CYCLES(LSC),
    .CNT_WIDTH         (16),
    .LOSS_CNT_WIDTH    (LCW)
  ) dut (
    .USER_CLK      (clk),
    .RESET_N       (rst_n),
    .GT_CLK_LOCKED (gt_lock),
    .CHANNEL_ENABLE(ch_en),
    .CLEAR_COUNTS  (clr),
    .LOCKED_STABLE (locked_stable),
    .PLL_NOT_LOCKED(pll_not_locked),
    .LOSS_COUNT    (loss_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        do_reset;
    logic [1:0]  lock;
    logic [1:0]  en;
    logic        clr;
    int unsigned ncyc;
    logic [1:0]  exp_locked;
    logic        exp_pnl;
    logic [7:0]  exp_loss;
  } vec_t;

  typedef struct {
    logic [1:0] locked;
    logic       pnl;
    logic [7:0] loss;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  function automatic vec_t mk(logic r, logic [1:0] lk, logic [1:0] e, logic c, int unsigned n,
                              logic [1:0] xl, logic xp, logic [7:0] xs);
    vec_t v;
    v.do_reset = r; v.lock = lk; v.en = e; v.clr = c; v.ncyc = n;
    v.exp_locked = xl; v.exp_pnl = xp; v.exp_loss = xs;
    return v;
  endfunction

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
    n_vec++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic compare_pop(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL %s: scoreboard empty", tag);
      return;
    end
    e = exp_q.pop_front();
    check({tag, " locked"}, {6'd0, locked_stable}, {6'd0, e.locked});
    check({tag, " pnl"},    {7'd0, pll_not_locked}, {7'd0, e.pnl});
    check({tag, " loss"},   loss_count, e.loss);
  endtask

  // Drive inputs just after a falling edge, let ncyc rising edges pass, sample at the next fall.
  task automatic apply(input string tag, input logic [1:0] lk, input logic [1:0] e, input logic c,
                       input int unsigned n, input logic [1:0] xl, input logic xp,
                       input logic [7:0] xs);
    exp_t x;
    gt_lock = lk; ch_en = e; clr = c;
    x.locked = xl; x.pnl = xp; x.loss = xs;
    exp_q.push_back(x);
    repeat (n) @(posedge clk);
    @(negedge clk);
    compare_pop(tag);
  endtask

  task automatic do_reset(input string tag);
    exp_t x;
    rst_n = 1'b0; gt_lock = '0; ch_en = '0; clr = 1'b0;
    repeat (2) @(negedge clk);
    x.locked = 2'b00; x.pnl = 1'b1; x.loss = 8'h00;
    exp_q.push_back(x);
    compare_pop(tag);
    rst_n = 1'b1;
  endtask

  initial begin
    exp_t x;
    logic [3:0] sat;
    rst_n = 1'b0; gt_lock = '0; ch_en = '0; clr = 1'b0;

    // Basic lock, then ch1 loss while locked and relock.
    vecs.push_back(mk(1, 2'b11, 2'b11, 0, 18, 2'b00, 1, 8'h00));
    vecs.push_back(mk(0, 2'b11, 2'b11, 0,  1, 2'b11, 1, 8'h00));
    vecs.push_back(mk(0, 2'b11, 2'b11, 0,  1, 2'b11, 0, 8'h00));
    vecs.push_back(mk(0, 2'b01, 2'b11, 0,  2, 2'b11, 0, 8'h00));
    vecs.push_back(mk(0, 2'b01, 2'b11, 0,  1, 2'b01, 0, 8'h10));
    vecs.push_back(mk(0, 2'b01, 2'b11, 0,  1, 2'b01, 1, 8'h10));
    vecs.push_back(mk(0, 2'b11, 2'b11, 0, 18, 2'b01, 1, 8'h10));
    vecs.push_back(mk(0, 2'b11, 2'b11, 0,  1, 2'b11, 1, 8'h10));
    vecs.push_back(mk(0, 2'b11, 2'b11, 0,  1, 2'b11, 0, 8'h10));
    // Dropout during qualify on ch0 (ch1 disabled, lock low), then enable masking.
    vecs.push_back(mk(1, 2'b01, 2'b01, 0, 11, 2'b00, 1, 8'h00));
    vecs.push_back(mk(0, 2'b00, 2'b01, 0,  3, 2'b00, 1, 8'h00));
    vecs.push_back(mk(0, 2'b01, 2'b01, 0, 18, 2'b00, 1, 8'h00));
    vecs.push_back(mk(0, 2'b01, 2'b01, 0,  1, 2'b01, 1, 8'h00));
    vecs.push_back(mk(0, 2'b01, 2'b01, 0,  1, 2'b01, 0, 8'h00));
    vecs.push_back(mk(0, 2'b01, 2'b00, 0,  2, 2'b00, 1, 8'h00));
    vecs.push_back(mk(0, 2'b01, 2'b01, 0, 16, 2'b00, 1, 8'h00));
    vecs.push_back(mk(0, 2'b01, 2'b01, 0,  1, 2'b01, 1, 8'h00));
    vecs.push_back(mk(0, 2'b01, 2'b01, 0,  1, 2'b01, 0, 8'h00));

    foreach (vecs[k]) begin
      if (vecs[k].do_reset) do_reset($sformatf("vec%0d reset", k));
      apply($sformatf("vec%0d", k), vecs[k].lock, vecs[k].en, vecs[k].clr, vecs[k].ncyc,
            vecs[k].exp_locked, vecs[k].exp_pnl, vecs[k].exp_loss);
    end

    // Saturation: 17 losses on ch0 must stop at 4'hF.
    for (int k = 1; k <= 17; k++) begin
      sat = (k > 15) ? 4'hF : 4'(k);
      apply($sformatf("sat%0d drop", k),  2'b00, 2'b01, 0,  3, 2'b00, 0, {4'h0, sat});
      apply($sformatf("sat%0d relock", k), 2'b01, 2'b01, 0, 20, 2'b01, 0, {4'h0, sat});
    end

    // Clear coinciding with a loss wins.
    apply("clr pre",   2'b00, 2'b01, 0, 2, 2'b01, 0, 8'h0F);
    apply("clr hit",   2'b00, 2'b01, 1, 1, 2'b00, 0, 8'h00);
    apply("clr after", 2'b00, 2'b01, 0, 1, 2'b00, 1, 8'h00);

    // Reset mid-lock: build a nonzero loss count first.
    apply("rml lock",   2'b11, 2'b11, 0, 20, 2'b11, 0, 8'h00);
    apply("rml drop",   2'b01, 2'b11, 0,  3, 2'b01, 0, 8'h10);
    apply("rml relock", 2'b11, 2'b11, 0, 20, 2'b11, 0, 8'h10);
    #1 rst_n = 1'b0;
    #1;
    x.locked = 2'b00; x.pnl = 1'b1; x.loss = 8'h00;
    exp_q.push_back(x);
    compare_pop("rml async");
    #1 rst_n = 1'b1;
    apply("rml requal a", 2'b11, 2'b11, 0, 18, 2'b00, 1, 8'h00);
    apply("rml requal b", 2'b11, 2'b11, 0,  1, 2'b11, 1, 8'h00);
    apply("rml requal c", 2'b11, 2'b11, 0,  1, 2'b11, 0, 8'h00);

    if (exp_q.size() != 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL scoreboard drain: %0d left expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
